// File: rtl/gamma_lut_ctrl_if.sv
// Host configuration bus of the gamma LUT stage. GAMMA_READBACK_EN adds the shadow readback pair.
`timescale 1ns/1ps
interface gamma_lut_ctrl_if;
  // Strobe bus, no ready: cfg_wr_en/cfg_commit are accepted only in cycles where cfg_busy is low.
  logic       cfg_wr_en;
  logic [7:0] cfg_wr_addr;
  logic [7:0] cfg_wr_data;
  logic       cfg_commit;
  logic       cfg_gamma_en;
  logic       cfg_busy;
  logic       active_bank;
`ifdef GAMMA_READBACK_EN
  logic [7:0] cfg_rd_addr;
  logic [7:0] cfg_rd_data;

  modport master (
    output cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_commit, cfg_gamma_en, cfg_rd_addr,
    input  cfg_busy, active_bank, cfg_rd_data
  );
  modport slave (
    input  cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_commit, cfg_gamma_en, cfg_rd_addr,
    output cfg_busy, active_bank, cfg_rd_data
  );
`else
  modport master (
    output cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_commit, cfg_gamma_en,
    input  cfg_busy, active_bank
  );
  modport slave (
    input  cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_commit, cfg_gamma_en,
    output cfg_busy, active_bank
  );
`endif
endinterface

// File: rtl/gamma_lut_ctrl.sv
// Double-buffered 256x8 gamma LUT with frame-synchronous bank swap and 2-cycle video pipeline.
// Optional shadow readback is enabled with `define GAMMA_READBACK_EN.
`timescale 1ns/1ps
module gamma_lut_ctrl #(
  parameter bit VS_POL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  gamma_lut_ctrl_if.slave cfg,
  input  logic       i_vs,
  input  logic       i_hs,
  input  logic       i_de,
  input  logic [7:0] i_r,
  input  logic [7:0] i_g,
  input  logic [7:0] i_b,
  output logic       o_vs,
  output logic       o_hs,
  output logic       o_de,
  output logic [7:0] o_r,
  output logic [7:0] o_g,
  output logic [7:0] o_b,
  output logic [1:0] fsm_state
);

  localparam int INIT_CYC = 256;
  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  logic [1:0] state;
  logic [7:0] init_cnt;
  logic       active_bank;
  logic       shadow_bank;
  logic       gamma_en_q;
  logic       vs_d;
  logic       frame_start;

  // Register-array LUT: three independent read ports fall out naturally.
  logic [7:0] lut [2][256];

  logic       s1_vs, s1_hs, s1_de, s1_bank, s1_en;
  logic [7:0] s1_r, s1_g, s1_b;

  assign shadow_bank   = ~active_bank;
  assign frame_start   = (i_vs == VS_POL) && (vs_d != VS_POL);
  assign fsm_state     = state;
  assign cfg.cfg_busy  = (state != ST_IDLE);
  assign cfg.active_bank = active_bank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_INIT;
      init_cnt    <= '0;
      active_bank <= 1'b0;
      gamma_en_q  <= 1'b0;
      vs_d        <= ~VS_POL;
    end else begin
      vs_d <= i_vs;
      if (frame_start) gamma_en_q <= cfg.cfg_gamma_en;
      case (state)
        ST_INIT: begin
          init_cnt <= init_cnt + 8'd1;
          if (init_cnt == 8'(INIT_CYC - 1)) state <= ST_IDLE;
        end
        ST_IDLE: begin
          // A commit coinciding with a frame start still waits for the next one.
          if (cfg.cfg_commit) state <= ST_PEND;
        end
        ST_PEND: begin
          if (frame_start) begin
            active_bank <= ~active_bank;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++)
        for (int k = 0; k < 256; k++)
          lut[b][k] <= '0;
    end else if (state == ST_INIT) begin
      lut[0][init_cnt] <= init_cnt;
      lut[1][init_cnt] <= init_cnt;
    end else if (state == ST_IDLE && cfg.cfg_wr_en) begin
      lut[shadow_bank][cfg.cfg_wr_addr] <= cfg.cfg_wr_data;
    end
  end

  // S1 captures bank/enable as they stand this cycle, so a swap only affects later pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vs   <= 1'b0;
      s1_hs   <= 1'b0;
      s1_de   <= 1'b0;
      s1_bank <= 1'b0;
      s1_en   <= 1'b0;
      s1_r    <= '0;
      s1_g    <= '0;
      s1_b    <= '0;
    end else begin
      s1_vs   <= i_vs;
      s1_hs   <= i_hs;
      s1_de   <= i_de;
      s1_bank <= active_bank;
      s1_en   <= gamma_en_q;
      s1_r    <= i_r;
      s1_g    <= i_g;
      s1_b    <= i_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_vs <= 1'b0;
      o_hs <= 1'b0;
      o_de <= 1'b0;
      o_r  <= '0;
      o_g  <= '0;
      o_b  <= '0;
    end else begin
      o_vs <= s1_vs;
      o_hs <= s1_hs;
      o_de <= s1_de;
      o_r  <= s1_en ? lut[s1_bank][s1_r] : s1_r;
      o_g  <= s1_en ? lut[s1_bank][s1_g] : s1_g;
      o_b  <= s1_en ? lut[s1_bank][s1_b] : s1_b;
    end
  end

`ifdef GAMMA_READBACK_EN
  logic [7:0] rd_data_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= lut[shadow_bank][cfg.cfg_rd_addr];
  end
  assign cfg.cfg_rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_gamma_lut_ctrl.sv
// Scoreboard bench for gamma_lut_ctrl: directed pixels with hand-computed results plus random sync traffic.
`timescale 1ns/1ps
module tb_gamma_lut_ctrl;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gamma_lut_ctrl_if cfg();
  logic       i_vs, i_hs, i_de;
  logic [7:0] i_r, i_g, i_b;
  logic       o_vs, o_hs, o_de;
  logic [7:0] o_r, o_g, o_b;
  logic [1:0] fsm_state;

  gamma_lut_ctrl #(.VS_POL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .cfg(cfg),
    .i_vs(i_vs), .i_hs(i_hs), .i_de(i_de), .i_r(i_r), .i_g(i_g), .i_b(i_b),
    .o_vs(o_vs), .o_hs(o_hs), .o_de(o_de), .o_r(o_r), .o_g(o_g), .o_b(o_b),
    .fsm_state(fsm_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [23:0] exp_q[$];
  logic [2:0]  h1, h2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pix(input logic [7:0] r, g, b, er, eg, eb);
    i_r = r; i_g = g; i_b = b; i_de = 1'b1;
    exp_q.push_back({er, eg, eb});
    tick();
    i_de = 1'b0;
  endtask

  task automatic fs_pix(input logic [7:0] r, g, b, er, eg, eb);
    i_vs = 1'b1;
    drive_pix(r, g, b, er, eg, eb);
    i_vs = 1'b0;
  endtask

  task automatic frame_start();
    i_vs = 1'b1;
    tick();
    i_vs = 1'b0;
    tick();
  endtask

  task automatic wait_init(input string name);
    int n;
    n = 0;
    while (cfg.cfg_busy && n < 400) begin
      tick();
      n++;
    end
    check(name, n, 256);
  endtask

  // scoreboard monitor: sync delay line every cycle, pixel pop on o_de
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h1 <= '0;
      h2 <= '0;
    end else begin
      h1 <= {i_vs, i_hs, i_de};
      h2 <= h1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("sync_delay", {o_vs, o_hs, o_de}, h2);
      if (o_de) begin
        if (exp_q.size() == 0) check("unexpected_pix", 1, 0);
        else check("pix_rgb", {o_r, o_g, o_b}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg.cfg_wr_en = 0; cfg.cfg_wr_addr = 0; cfg.cfg_wr_data = 0;
    cfg.cfg_commit = 0; cfg.cfg_gamma_en = 0;
`ifdef GAMMA_READBACK_EN
    cfg.cfg_rd_addr = 0;
`endif
    i_vs = 0; i_hs = 0; i_de = 0; i_r = 0; i_g = 0; i_b = 0;

    // reset state
    repeat (3) tick();
    check("rst_o_de", o_de, 0);
    check("rst_o_r", o_r, 0);
    check("rst_bank", cfg.active_bank, 0);
    check("rst_busy", cfg.cfg_busy, 1);
    rst_n = 1'b1;
    wait_init("init_len");

    // identity after init
    cfg.cfg_gamma_en = 1;
    frame_start();
    drive_pix(8'd37, 8'd37, 8'd37, 8'd37, 8'd37, 8'd37);

    // inverse curve into shadow; last write shares its cycle with the commit
    for (int k = 0; k < 256; k++) begin
      cfg.cfg_wr_en = 1; cfg.cfg_wr_addr = 8'(k); cfg.cfg_wr_data = 8'(255 - k);
      cfg.cfg_commit = (k == 255);
      tick();
    end
    cfg.cfg_wr_en = 0; cfg.cfg_commit = 0;
    check("pend_busy", cfg.cfg_busy, 1);
    check("pend_bank", cfg.active_bank, 0);
    drive_pix(8'd0, 8'd10, 8'd255, 8'd0, 8'd10, 8'd255);
    fs_pix(8'd0, 8'd20, 8'd255, 8'd0, 8'd20, 8'd255);
    check("swap_bank", cfg.active_bank, 1);
    check("swap_busy", cfg.cfg_busy, 0);
    drive_pix(8'd0, 8'd10, 8'd255, 8'd255, 8'd245, 8'd0);

    // write during PENDING is dropped
    cfg.cfg_commit = 1; tick(); cfg.cfg_commit = 0;
    cfg.cfg_wr_en = 1; cfg.cfg_wr_addr = 8'd5; cfg.cfg_wr_data = 8'd99; tick();
    cfg.cfg_wr_en = 0;
    frame_start();
    check("swap2_bank", cfg.active_bank, 0);
    drive_pix(8'd5, 8'd250, 8'd5, 8'd5, 8'd250, 8'd5);

    // commit on a frame-start cycle waits for the following frame start
    cfg.cfg_commit = 1; i_vs = 1; tick();
    cfg.cfg_commit = 0; i_vs = 0;
    check("fs_commit_busy", cfg.cfg_busy, 1);
    check("fs_commit_bank", cfg.active_bank, 0);
    tick();
    frame_start();
    check("swap3_bank", cfg.active_bank, 1);
    drive_pix(8'd5, 8'd0, 8'd0, 8'd250, 8'd255, 8'd255);

    // bypass takes effect only after the next frame start
    cfg.cfg_gamma_en = 0;
    drive_pix(8'd0, 8'd0, 8'd3, 8'd255, 8'd255, 8'd252);
    fs_pix(8'd0, 8'd0, 8'd4, 8'd255, 8'd255, 8'd251);
    drive_pix(8'd0, 8'd0, 8'd4, 8'd0, 8'd0, 8'd4);

    // random syncs in bypass
    for (int c = 0; c < 300; c++) begin
      i_vs = 1'($urandom_range(0, 1));
      i_hs = 1'($urandom_range(0, 1));
      i_r = 8'($urandom_range(0, 255));
      i_g = 8'($urandom_range(0, 255));
      i_b = 8'($urandom_range(0, 255));
      i_de = 1'($urandom_range(0, 1));
      if (i_de) exp_q.push_back({i_r, i_g, i_b});
      tick();
    end
    i_vs = 0; i_hs = 0; i_de = 0;
    repeat (4) tick();

`ifdef GAMMA_READBACK_EN
    cfg.cfg_wr_en = 1; cfg.cfg_wr_addr = 8'd200; cfg.cfg_wr_data = 8'd17; tick();
    cfg.cfg_wr_en = 0; cfg.cfg_rd_addr = 8'd200; tick();
    check("rd_200", cfg.cfg_rd_data, 17);
    cfg.cfg_rd_addr = 8'd5; tick();
    check("rd_5", cfg.cfg_rd_data, 5);
`endif

    // asynchronous reset mid-frame
    i_hs = 1;
    drive_pix(8'd7, 8'd8, 8'd9, 8'd7, 8'd8, 8'd9);
    drive_pix(8'd1, 8'd2, 8'd3, 8'd1, 8'd2, 8'd3);
    check("pre_rst_o_r", o_r, 7);
    rst_n = 1'b0;
    #1;
    check("arst_o_r", o_r, 0);
    check("arst_o_de", o_de, 0);
    check("arst_o_hs", o_hs, 0);
    check("arst_bank", cfg.active_bank, 0);
    check("arst_busy", cfg.cfg_busy, 1);
    exp_q.delete();
    i_hs = 0;
    tick();
    rst_n = 1'b1;
    wait_init("reinit_len");
    cfg.cfg_gamma_en = 1;
    frame_start();
    drive_pix(8'd200, 8'd10, 8'd5, 8'd200, 8'd10, 8'd5);
    cfg.cfg_commit = 1; tick(); cfg.cfg_commit = 0;
    frame_start();
    check("reinit_bank", cfg.active_bank, 1);
    drive_pix(8'd200, 8'd10, 8'd5, 8'd200, 8'd10, 8'd5);

    repeat (4) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
